// File: rtl/color_clock_render_pkg.sv
// Shared constants, colour codes and band encoding for the time-of-day bar renderer.
package color_clock_render_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned SEC_MAX  = 59;
  localparam int unsigned MIN_MAX  = 59;
  localparam int unsigned HR_MAX   = 23;
  localparam int unsigned HR_SCALE = 26;
  localparam int unsigned MS_SCALE = 10;

  typedef logic [11:0] rgb_t;

  localparam rgb_t COL_HR  = 12'hF00;
  localparam rgb_t COL_MIN = 12'h0F0;
  localparam rgb_t COL_SEC = 12'h00F;
  localparam rgb_t COL_BG  = 12'h111;

  typedef enum logic [1:0] {
    BAND_HR,
    BAND_MIN,
    BAND_SEC
  } band_e;

  // Bar length in pixels; the product is deliberately truncated to 10 bits.
  function automatic logic [9:0] bar_scale(input logic [5:0] v, input int unsigned k);
    return {4'b0, v} * 10'(k);
  endfunction

endpackage

// File: rtl/color_clock_render_time_of_day_counter.sv
// Seconds prescaler and hh:mm:ss counter with a minute-advance input.
module time_of_day_counter
  import color_clock_render_pkg::*;
#(
  parameter int unsigned CLK_HZ = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       adv_min,
  output logic [4:0] hr_o,
  output logic [5:0] min_o,
  output logic [5:0] sec_o
);

  localparam logic [24:0] PRE_TC = 25'(CLK_HZ - 1);
  localparam logic [5:0]  SEC_TC = 6'(SEC_MAX);
  localparam logic [5:0]  MIN_TC = 6'(MIN_MAX);
  localparam logic [4:0]  HR_TC  = 5'(HR_MAX);

  logic [24:0] pre_q, pre_d;
  logic [5:0]  sec_q, sec_d;
  logic [5:0]  min_q, min_d;
  logic [4:0]  hr_q, hr_d;
  logic        sec_tick;
  logic        min_carry;

  always_comb begin
    pre_d     = pre_q;
    sec_d     = sec_q;
    min_d     = min_q;
    hr_d      = hr_q;
    sec_tick  = (pre_q == PRE_TC);
    min_carry = 1'b0;

    // adv_min wins over a coincident tick: the tick is dropped, minutes move by one.
    if (adv_min) begin
      pre_d     = '0;
      sec_d     = '0;
      min_carry = 1'b1;
    end else if (sec_tick) begin
      pre_d = '0;
      if (sec_q == SEC_TC) begin
        sec_d     = '0;
        min_carry = 1'b1;
      end else begin
        sec_d = sec_q + 1'b1;
      end
    end else begin
      pre_d = pre_q + 1'b1;
    end

    if (min_carry) begin
      if (min_q == MIN_TC) begin
        min_d = '0;
        hr_d  = (hr_q == HR_TC) ? '0 : hr_q + 1'b1;
      end else begin
        min_d = min_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      sec_q <= '0;
      min_q <= '0;
      hr_q  <= '0;
    end else begin
      pre_q <= pre_d;
      sec_q <= sec_d;
      min_q <= min_d;
      hr_q  <= hr_d;
    end
  end

  assign hr_o  = hr_q;
  assign min_o = min_q;
  assign sec_o = sec_q;

endmodule

// File: rtl/color_clock_render.sv
// Renders hours/minutes/seconds as three horizontal bar bands behind a VGA sync generator.
module color_clock_render
  import color_clock_render_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 25000000,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1,
  parameter int unsigned BAND_H          = 160
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       h_sync_in,
  input  logic       v_sync_in,
  input  logic       onscreen_in,
  input  logic       adv_min,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       h_sync_out,
  output logic       v_sync_out
);

  localparam logic [9:0] X_MAX   = 10'(H_ACTIVE - 1);
  localparam logic [8:0] Y_MAX   = 9'(V_ACTIVE - 1);
  localparam logic [8:0] BAND1_Y = 9'(BAND_H);
  localparam logic [8:0] BAND2_Y = 9'(2 * BAND_H);
  localparam logic       SYNC_IDLE = SYNC_ACTIVE_LOW;

  logic [4:0] hr;
  logic [5:0] min_live, sec_live;

  time_of_day_counter #(.CLK_HZ(CLK_HZ)) u_tod (
    .clk     (clk),
    .rst_n   (rst_n),
    .adv_min (adv_min),
    .hr_o    (hr),
    .min_o   (min_live),
    .sec_o   (sec_live)
  );

  logic [9:0] x_q, x_d;
  logic [8:0] y_q, y_d;
  logic       on_q, on_d;
  logic       vs_act_q, vs_act_d;
  logic [4:0] hr_s_q, hr_s_d;
  logic [5:0] min_s_q, min_s_d;
  logic [5:0] sec_s_q, sec_s_d;
  rgb_t       rgb_q, rgb_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;

  logic       vs_act;
  logic       vs_edge;
  band_e      band;
  logic [9:0] bar_len;
  rgb_t       bar_col;

  assign vs_act = v_sync_in ^ SYNC_ACTIVE_LOW;

  always_comb begin
    x_d = '0;
    if (onscreen_in) x_d = (x_q == X_MAX) ? x_q : x_q + 1'b1;

    y_d = y_q;
    if (vs_act) y_d = '0;
    else if (on_q && !onscreen_in && (y_q != Y_MAX)) y_d = y_q + 1'b1;

    on_d     = onscreen_in;
    vs_act_d = vs_act;
    vs_edge  = vs_act && !vs_act_q;

    // Shadow copy taken once per frame so a frame never mixes two time values.
    hr_s_d  = vs_edge ? hr       : hr_s_q;
    min_s_d = vs_edge ? min_live : min_s_q;
    sec_s_d = vs_edge ? sec_live : sec_s_q;

    if (y_q < BAND1_Y)      band = BAND_HR;
    else if (y_q < BAND2_Y) band = BAND_MIN;
    else                    band = BAND_SEC;

    case (band)
      BAND_HR: begin
        bar_len = bar_scale({1'b0, hr_s_q}, HR_SCALE);
        bar_col = COL_HR;
      end
      BAND_MIN: begin
        bar_len = bar_scale(min_s_q, MS_SCALE);
        bar_col = COL_MIN;
      end
      default: begin
        bar_len = bar_scale(sec_s_q, MS_SCALE);
        bar_col = COL_SEC;
      end
    endcase

    if (!onscreen_in)       rgb_d = '0;
    else if (x_q < bar_len) rgb_d = bar_col;
    else                    rgb_d = COL_BG;

    hs_d = h_sync_in;
    vs_d = v_sync_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q      <= '0;
      y_q      <= '0;
      on_q     <= 1'b0;
      vs_act_q <= 1'b0;
      hr_s_q   <= '0;
      min_s_q  <= '0;
      sec_s_q  <= '0;
      rgb_q    <= '0;
      hs_q     <= SYNC_IDLE;
      vs_q     <= SYNC_IDLE;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      on_q     <= on_d;
      vs_act_q <= vs_act_d;
      hr_s_q   <= hr_s_d;
      min_s_q  <= min_s_d;
      sec_s_q  <= sec_s_d;
      rgb_q    <= rgb_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
    end
  end

  assign red        = rgb_q[11:8];
  assign green      = rgb_q[7:4];
  assign blue       = rgb_q[3:0];
  assign h_sync_out = hs_q;
  assign v_sync_out = vs_q;

endmodule
